key_expansion: RTL and testbench
================================

// Module: key_expansion
// PURPOSE
//   Sequential AES key schedule (FIPS-197 sec 5.2) for AES-128/192/256.
//   - Expands a cipher key into all Nr+1 round keys, one 32-bit word per clock.
//   - Packs the keys into one flat vector consumed by the AddRoundKey/EncryptRound datapath.
//   - Holds the result stable until the next start.
// PARAMETERS
//   Nk  4   key length in 32-bit words; legal values 4, 6, 8
//   Nr  10  number of rounds; must be Nk+6 (10, 12, 14)
// PORTS
//   clk      in   1               clock; all state on rising edge
//   reset    in   1               asynchronous, active-high reset
//   start    in   1               begin expansion of key; sampled on clk rise
//   key      in   Nk*32           cipher key; MSB word is w[0]
//   allKeys  out  (Nr+1)*128      round keys; round 0 in MSBs, round Nr in LSBs
//   busy     out  1               high while words are being generated
//   done     out  1               high once allKeys is complete; held until next start
// BEHAVIOUR
//   Reset (async, any time, including mid-expansion):
//     - allKeys=0, busy=0, done=0, word index cleared.
//     - No partial result survives.
//   Word map: w[i] occupies allKeys[(Nr+1)*128-1-32*i -: 32], i = 0..4*(Nr+1)-1.
//   Start (start=1 and busy=0), registered on that edge:
//     - w[0..Nk-1] = key; all other words = 0.
//     - busy=1, done=0, i=Nk.
//     - key is sampled only on this edge; later changes to key are ignored.
//   Generation, one word per cycle while busy:
//     - temp = w[i-1]
//     - if i%Nk==0:             temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk],24'h0}
//     - else if Nk>6 & i%Nk==4: temp = SubWord(temp)
//     - w[i] = w[i-Nk] ^ temp;  i = i+1
//   RotWord {a,b,c,d} -> {b,c,d,a}.
//   SubWord: AES S-box applied to each byte; S-box is a combinational 256-entry table.
//   Rcon: 01,02,04,08,10,20,40,80,1b,36 (xtime in GF(2^8), poly 11b).
//   Completion:
//     - The cycle that writes w[4*(Nr+1)-1] sets busy=0 and done=1.
//     - Latency, start edge to done: 4*(Nr+1)-Nk+1 edges = 41 / 47 / 53 for Nk = 4 / 6 / 8.
//   Other rules:
//     - start while busy: ignored; the current expansion continues.
//     - start while done: restarts; done drops on that edge.
//     - During expansion, words already written are valid and later words read 0.
//       Consumers use allKeys only when done=1.
//     - All arithmetic is bytewise XOR; no carries; widths fixed by the parameters.
// TESTING
//   1 Nk=4, key=000102030405060708090a0b0c0d0e0f, start 1 cycle
//     -> done after 41 edges; round-0 key = key;
//        round-10 key = 13111d7fe3944a17f307a78b4d2b30c5
//   2 Nk=4, key=2b7e151628aed2a6abf7158809cf4f3c
//     -> w[4]=a0fafe17;
//        round-10 key = d014f9a8c9ee2589e13f0cc8b6630ca6
//   3 Nk=6, key=000102..1617
//     -> round-1 key = 10111213141516175846f2f95c43f4fe;
//        round-12 key = a4970a331a78dc09c418c271e3a41d5d; done after 47 edges
//   4 Nk=8, key=000102..1e1f
//     -> round-14 key = 24fc79ccbf0979e9371ac23c6d68de36; done after 53 edges
//   5 Assert reset at cycle 20 of an expansion
//     -> allKeys=0, busy=0, done=0 immediately;
//        a new start then gives the case-1 result
//   6 Pulse start at cycle 10 with a different key
//     -> ignored; result equals the first key's schedule;
//        start after done -> done drops, new schedule completes

Source files
------------

// File: rtl/key_expansion.sv
// AES key schedule for AES-128/192/256.
// Generates one 32-bit round-key word per clock. The full schedule is packed into
// allKeys with round 0 in the MSBs. The result is held until the next accepted start.
module key_expansion #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [Nk*32-1:0]       key,
    output logic [(Nr+1)*128-1:0]  allKeys,
    output logic                   busy,
    output logic                   done
);

    localparam int NW = 4 * (Nr + 1);
    localparam int IW = $clog2(NW + 1);

    // AES S-box. Entry 0 occupies the top byte, so entry b sits at bits {~b, 3'b111} -: 8.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [2047:0] table_bits;
        table_bits = SBOX;
        return table_bits[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [IW-1:0] i_reg;      // index of the word written on the next edge
    logic [3:0]    pos_reg;    // i mod Nk, tracked incrementally
    logic [7:0]    rcon_reg;   // Rcon[i/Nk] for the next word with pos_reg == 0
    logic          busy_reg;
    logic          done_reg;
    logic [31:0]   window_reg [Nk];   // w[i-Nk] .. w[i-1]
    logic [31:0]   next_word;
    logic [31:0]   temp;
    logic          start_ok;

    assign start_ok = start && !busy_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

    // Key-schedule recurrence for the word at index i_reg.
    always_comb begin
        temp = window_reg[Nk-1];
        if (pos_reg == 4'd0) begin
            temp = sub_word({window_reg[Nk-1][23:0], window_reg[Nk-1][31:24]}) ^ {rcon_reg, 24'h0};
        end else if (Nk > 6 && pos_reg == 4'd4) begin
            temp = sub_word(window_reg[Nk-1]);
        end
        next_word = window_reg[0] ^ temp;
    end

    // Sequencing: index, position within the key period, Rcon, busy and done flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_reg    <= '0;
            pos_reg  <= '0;
            rcon_reg <= 8'h01;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else if (start_ok) begin
            i_reg    <= IW'(Nk);
            pos_reg  <= '0;
            rcon_reg <= 8'h01;
            busy_reg <= 1'b1;
            done_reg <= 1'b0;
        end else if (busy_reg) begin
            i_reg   <= i_reg + IW'(1);
            pos_reg <= (pos_reg == 4'(Nk - 1)) ? 4'd0 : pos_reg + 4'd1;
            if (pos_reg == 4'd0) begin
                rcon_reg <= xtime(rcon_reg);
            end
            if (i_reg == IW'(NW - 1)) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

    // Sliding window of the last Nk words feeding the recurrence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < Nk; j++) begin
                window_reg[j] <= '0;
            end
        end else if (start_ok) begin
            for (int j = 0; j < Nk; j++) begin
                window_reg[j] <= key[Nk*32-1-32*j -: 32];
            end
        end else if (busy_reg) begin
            for (int j = 0; j < Nk - 1; j++) begin
                window_reg[j] <= window_reg[j+1];
            end
            window_reg[Nk-1] <= next_word;
        end
    end

    // Output storage: one register per schedule word, w[0] in the MSBs.
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
        if (gi < Nk) begin : g_key
            logic [31:0] word_reg;
            // Cipher-key words are captured only on an accepted start.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (start_ok) begin
                    word_reg <= key[Nk*32-1-32*gi -: 32];
                end
            end
            assign allKeys[(NW-gi)*32-1 -: 32] = word_reg;
        end else begin : g_gen
            logic [31:0] word_reg;
            // Generated words clear on start and fill in when their index comes up.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (start_ok) begin
                    word_reg <= '0;
                end else if (busy_reg && i_reg == IW'(gi)) begin
                    word_reg <= next_word;
                end
            end
            assign allKeys[(NW-gi)*32-1 -: 32] = word_reg;
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion: three instances (Nk = 4, 6, 8) checked against
// a reference schedule built from GF(2^8) arithmetic.
module tb_key_expansion;

    logic         clk;
    logic         reset;
    logic         start4, start6, start8;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic [1407:0] all4;
    logic [1663:0] all6;
    logic [1919:0] all8;
    logic         busy4, busy6, busy8;
    logic         done4, done6, done8;

    key_expansion #(.Nk(4), .Nr(10)) dut4 (.clk(clk), .reset(reset), .start(start4), .key(key4),
                                           .allKeys(all4), .busy(busy4), .done(done4));
    key_expansion #(.Nk(6), .Nr(12)) dut6 (.clk(clk), .reset(reset), .start(start6), .key(key6),
                                           .allKeys(all6), .busy(busy6), .done(done6));
    key_expansion #(.Nk(8), .Nr(14)) dut8 (.clk(clk), .reset(reset), .start(start8), .key(key8),
                                           .allKeys(all8), .busy(busy8), .done(done8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    typedef struct {
        logic [1919:0] keys;
        int            iss;
    } sb_t;
    sb_t q4[$];
    sb_t q6[$];
    sb_t q8[$];
    int  last_iss4;

    // ---------------- reference model ----------------
    logic [7:0] sbox_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sw(input logic [31:0] t);
        return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
    endfunction

    // Full schedule, right-aligned, w[0] most significant.
    function automatic logic [1919:0] model(input int nk, input logic [255:0] k);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] res;
        int            nw;
        nw = 4 * (nk + 7);
        for (int j = 0; j < nk; j++) w[j] = k[nk*32-1-32*j -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int r = 1; r < i / nk; r++) rc = gmul(rc, 8'h02);
                t = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = sw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        res = '0;
        for (int i = 0; i < nw; i++) res = {res[1887:0], w[i]};
        return res;
    endfunction

    function automatic logic [1919:0] partial(input logic [1919:0] full, input int nk, input int valid);
        logic [1919:0] res;
        int nw;
        nw  = 4 * (nk + 7);
        res = full;
        for (int i = valid; i < nw; i++) res[(nw-1-i)*32 +: 32] = 32'h0;
        return res;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_vec(input string name, input logic [1919:0] act, input logic [1919:0] exp, input int nk);
        int nw;
        int bad;
        nw  = 4 * (nk + 7);
        bad = -1;
        for (int i = nw - 1; i >= 0; i--) begin
            if (act[(nw-1-i)*32 +: 32] !== exp[(nw-1-i)*32 +: 32]) bad = i;
        end
        tot_cnt++;
        if (bad < 0) pass_cnt++;
        else $display("FAIL %s: word %0d got %h expected %h", name, bad,
                      act[(nw-1-bad)*32 +: 32], exp[(nw-1-bad)*32 +: 32]);
    endtask

    task automatic check_txn(input int nk, input logic [1919:0] act, input logic b, input sb_t e);
        int lat;
        lat = cyc - e.iss;
        chk_vec($sformatf("nk%0d schedule", nk), act, e.keys, nk);
        chk128($sformatf("nk%0d latency", nk), 128'(lat), 128'(4 * (nk + 7) - nk + 1));
        chk128($sformatf("nk%0d busy at done", nk), 128'(b), 128'(0));
        $display("txn nk=%0d latency=%0d round0=%h", nk, lat, act[(4*(nk+7))*32-1 -: 128]);
    endtask

    // ---------------- monitor ----------------
    logic pd4 = 1'b0, pd6 = 1'b0, pd8 = 1'b0;
    always @(negedge clk) begin
        if (done4 && !pd4) begin
            tot_cnt++;
            if (q4.size() == 0) $display("FAIL nk4 unexpected done: got 1 expected 0");
            else begin pass_cnt++; check_txn(4, {512'h0, all4}, busy4, q4.pop_front()); end
        end
        if (done6 && !pd6) begin
            tot_cnt++;
            if (q6.size() == 0) $display("FAIL nk6 unexpected done: got 1 expected 0");
            else begin pass_cnt++; check_txn(6, {256'h0, all6}, busy6, q6.pop_front()); end
        end
        if (done8 && !pd8) begin
            tot_cnt++;
            if (q8.size() == 0) $display("FAIL nk8 unexpected done: got 1 expected 0");
            else begin pass_cnt++; check_txn(8, all8, busy8, q8.pop_front()); end
        end
        pd4 = done4;
        pd6 = done6;
        pd8 = done8;
    end

    // ---------------- driver ----------------
    task automatic issue(input int nk, input logic [255:0] k, input bit push);
        sb_t e;
        @(negedge clk);
        e.keys = model(nk, k);
        e.iss  = cyc;
        case (nk)
            4: begin key4 = k[127:0]; start4 = 1'b1; last_iss4 = cyc; if (push) q4.push_back(e); end
            6: begin key6 = k[191:0]; start6 = 1'b1; if (push) q6.push_back(e); end
            default: begin key8 = k; start8 = 1'b1; if (push) q8.push_back(e); end
        endcase
        @(negedge clk);
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
        // Key must be ignored after the start edge.
        key4 = {$urandom, $urandom, $urandom, $urandom};
        key6 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        key8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    function automatic logic sel_done(input int nk);
        case (nk)
            4: return done4;
            6: return done6;
            default: return done8;
        endcase
    endfunction

    task automatic wait_done(input int nk, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sel_done(nk)) return;
        end
        tot_cnt++;
        $display("FAIL nk%0d done timeout: got 0 expected 1", nk);
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_idle(input string tag);
        chk128({tag, " all4"}, all4[127:0] | all4[1407:1280], 128'h0);
        chk128({tag, " all6"}, all6[127:0] | all6[1663:1536], 128'h0);
        chk128({tag, " all8"}, all8[127:0] | all8[1919:1792], 128'h0);
        chk128({tag, " busy"}, 128'({busy4, busy6, busy8}), 128'h0);
        chk128({tag, " done"}, 128'({done4, done6, done8}), 128'h0);
    endtask

    localparam logic [255:0] K1  = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K2  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K4  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    initial begin
        logic [255:0] kb;
        reset  = 1'b1;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        key4 = '0; key6 = '0; key8 = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // Known-answer schedules.
        issue(4, K1, 1);
        wait_done(4, 100);
        chk128("c1 round0", all4[1407:1280], K1[127:0]);
        chk128("c1 round10", all4[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        issue(4, K2, 1);
        wait_done(4, 100);
        chk128("c2 w4", 128'(all4[1279:1248]), 128'ha0fafe17);
        chk128("c2 round10", all4[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        issue(6, K3, 1);
        wait_done(6, 100);
        chk128("c3 round1", all6[1535:1408], 128'h10111213141516175846f2f95c43f4fe);
        chk128("c3 round12", all6[127:0], 128'ha4970a331a78dc09c418c271e3a41d5d);

        issue(8, K4, 1);
        wait_done(8, 100);
        chk128("c4 round14", all8[127:0], 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // Reset in the middle of an expansion.
        issue(4, K1, 1);
        repeat (19) @(negedge clk);
        chk_vec("mid-expansion partial", {512'h0, all4},
                partial(model(4, K1), 4, 4 + (cyc - last_iss4) - 1), 4);
        #2 reset = 1'b1;
        q4.delete();
        #1 check_idle("async reset");
        @(negedge clk);
        reset = 1'b0;
        issue(4, K1, 1);
        wait_done(4, 100);
        chk128("c5 round10", all4[127:0], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Start while busy is ignored; start while done restarts.
        kb = rand_key();
        issue(4, K2, 1);
        repeat (9) @(negedge clk);
        issue(4, kb, 0);
        wait_done(4, 100);
        chk128("c6 round10", all4[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        issue(4, kb, 1);
        chk128("c6 restart done", 128'(done4), 128'h0);
        chk128("c6 restart busy", 128'(busy4), 128'h1);
        wait_done(4, 100);

        // Randomized keys on all three widths, running concurrently.
        for (int r = 0; r < 4; r++) begin
            issue(4, rand_key(), 1);
            issue(6, rand_key(), 1);
            issue(8, rand_key(), 1);
            wait_done(4, 100);
            wait_done(6, 100);
            wait_done(8, 100);
        end

        repeat (3) @(negedge clk);
        chk128("scoreboard drained", 128'(q4.size() + q6.size() + q8.size()), 128'h0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
